// File: rtl/dac_pkg.sv
// -----------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the DAC sample path: the sample word width and type,
// the idle (midscale) output code, and the playback FSM state encoding. The
// DAC serial driver imports the same package so both ends agree on widths.
// Ports: none (package).
// -----------------------------------------------------------------------------
package dac_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Output code presented while playback is not running.
    localparam sample_t DAC_MIDSCALE = 16'h8000;

    // Playback FSM encoding, kept as plain 2-bit constants so legacy blocks
    // that decode the state vector keep working.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PRIME = 2'd1;
    localparam state_t ST_RUN   = 2'd2;

endpackage

// File: rtl/dac_sample_feeder_if.sv
// -----------------------------------------------------------------------------
// dac_sample_feeder_if
// Valid/ready sample stream from the producer into the DAC sample feeder.
//   in_data   producer -> feeder  unsigned sample word
//   in_valid  producer -> feeder  in_data is valid
//   in_ready  feeder -> producer  feeder can accept a word this cycle
// Modports: master = producer side, slave = feeder side.
// -----------------------------------------------------------------------------
interface dac_sample_feeder_if
    import dac_pkg::*;
();

    sample_t in_data;
    logic    in_valid;
    logic    in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Synchronous single-clock FIFO for DAC samples with a registered read port.
// A pop loads the head word into rdata on the clock edge; rdata then holds
// until the next successful pop. Push on full and pop on empty are ignored,
// so nothing is overwritten and no bypass path exists from wdata to rdata.
//   clk    system clock
//   rst    synchronous active-high reset; empties the FIFO
//   push   write request (ignored while full)
//   wdata  word to write
//   pop    read request (ignored while empty)
//   rdata  last popped word
//   level  current occupancy, 0..DEPTH
//   full   level == DEPTH
//   empty  level == 0
// -----------------------------------------------------------------------------
module sample_fifo
    import dac_pkg::*;
#(
    parameter int DEPTH = 16
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  sample_t                  wdata,
    input  logic                     pop,
    output sample_t                  rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    sample_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are AW bits wide, so the +1 wraps modulo DEPTH on its own.
    // NOTE: sequential state is written with non-blocking (<=) assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rdata  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                rdata  <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the pointers and level define
    // which entries are meaningful, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// -----------------------------------------------------------------------------
// dac_sample_feeder
// Buffers producer samples in a FIFO and releases one word every `period`
// clocks to the DAC serial driver. Playback runs IDLE -> PRIME -> RUN: PRIME
// waits until PRIME_LVL words are buffered so the stream starts with margin;
// RUN pops on a down-counting period divider.
//   clk          system clock
//   rst          synchronous active-high reset
//   enable       playback enable; low returns to IDLE (FIFO contents kept)
//   period       clocks per output sample; 0 and 1 behave as 2
//   src          producer stream (in_data / in_valid / in_ready)
//   data         sample to the DAC; MIDSCALE until the first pop of a run
//   sample_tick  one-cycle pulse in the cycle after data changes on a pop
//   underrun     sticky; set when a pop finds the FIFO empty
//   level        current FIFO occupancy
// -----------------------------------------------------------------------------
module dac_sample_feeder
    import dac_pkg::*;
#(
    parameter int      DEPTH     = 16,
    parameter int      PRIME_LVL = 8,
    parameter int      DIV_W     = 8,
    parameter sample_t MIDSCALE  = DAC_MIDSCALE
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         period,
    dac_sample_feeder_if.slave       src,
    output sample_t                  data,
    output logic                     sample_tick,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    PRIME_THR = (AW+1)'(PRIME_LVL);

    state_t              state;
    state_t              state_nxt;
    logic [DIV_W-1:0]    cnt;
    logic [DIV_W-1:0]    reload;
    logic                push;
    logic                pop_req;
    logic                fifo_full;
    logic                fifo_empty;
    logic [AW:0]         level_in;
    logic                have_sample;
    logic                tick_d1;
    sample_t             fifo_rdata;

    assign push         = src.in_valid && !fifo_full;
    assign src.in_ready = !fifo_full;

    // Occupancy including this cycle's push; cannot exceed DEPTH because a
    // push only happens when the FIFO is not full.
    assign level_in = level + {{AW{1'b0}}, push};

    // A pop attempt happens in RUN when the divider reaches zero; enable low
    // suppresses it because the block is leaving RUN on this edge.
    assign pop_req = (state == ST_RUN) && enable && (cnt == '0);

    // Interval length minus one, with periods below 2 clamped to 2. Sampled
    // only on a reload, so a period change never cuts a running interval.
    assign reload = (period < DIV_W'(2)) ? DIV_W'(1) : period - 1'b1;

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (src.in_data),
        .pop   (pop_req),
        .rdata (fifo_rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: every output of this combinational block gets a default before the
    // case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_PRIME;
                ST_PRIME: if (level_in >= PRIME_THR) state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            have_sample <= 1'b0;
            tick_d1     <= 1'b0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state <= state_nxt;

            // Counter only runs in RUN; held at zero elsewhere so the first
            // RUN cycle pops immediately.
            if ((state == ST_RUN) && enable) begin
                cnt <= (cnt == '0) ? reload : cnt - 1'b1;
            end else begin
                cnt <= '0;
            end

            // data follows the FIFO read register one cycle after the pop, so
            // the tick is delayed two cycles to land after the data change.
            tick_d1     <= pop_req;
            sample_tick <= tick_d1;

            if (pop_req && fifo_empty) begin
                underrun <= 1'b1;
            end else if ((state == ST_IDLE) && (state_nxt == ST_PRIME)) begin
                underrun <= 1'b0;
            end

            // have_sample selects the popped word over MIDSCALE; an empty pop
            // leaves it (and the read register) untouched so data holds.
            if (state_nxt == ST_IDLE) begin
                have_sample <= 1'b0;
            end else if (pop_req && !fifo_empty) begin
                have_sample <= 1'b1;
            end
        end
    end

    assign data = have_sample ? fifo_rdata : MIDSCALE;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_dac_sample_feeder
// Directed self-checking bench for dac_sample_feeder (DEPTH 16, PRIME_LVL 8,
// DIV_W 8). Expected values are hand-derived from the playback timing:
// enable high at cycle t0 gives PRIME at t0+1, RUN at t0+2, first data at t0+3
// and first sample_tick at t0+4.
// -----------------------------------------------------------------------------
module tb_dac_sample_feeder;
    import dac_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  period;
    sample_t     data;
    logic        sample_tick;
    logic        underrun;
    logic [4:0]  level;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int tick_cnt = 0;

    dac_sample_feeder_if src_if ();

    dac_sample_feeder #(
        .DEPTH     (16),
        .PRIME_LVL (8),
        .DIV_W     (8),
        .MIDSCALE  (16'h8000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .period      (period),
        .src         (src_if),
        .data        (data),
        .sample_tick (sample_tick),
        .underrun    (underrun),
        .level       (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sample_tick) tick_cnt <= tick_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        enable          = 1'b0;
        period          = 8'd4;
        src_if.in_valid = 1'b0;
        src_if.in_data  = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_seq(input sample_t base, input int n);
        src_if.in_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            src_if.in_data = base + sample_t'(i);
            step();
        end
        src_if.in_valid = 1'b0;
    endtask

    // Advance until sample_tick is seen; returns the cycle number of the tick.
    task automatic wait_tick(input string name, output int t);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_tick && n < 64);
        if (!sample_tick) begin
            n_checks++;
            $display("FAIL %s: no sample_tick within 64 cycles", name);
        end
        t = cyc;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (data !== 16'h8000) $display("FAIL reset_data: got %h want 8000", data); else n_pass++;
        n_checks++; if (sample_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", sample_tick); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else n_pass++;
        n_checks++; if (level !== 5'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (src_if.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", src_if.in_ready); else n_pass++;
    endtask

    task automatic test_idle_push();
        int t0;
        do_reset();
        t0 = tick_cnt;
        push_seq(16'h0050, 5);
        step();
        step();
        n_checks++; if (data !== 16'h8000) $display("FAIL idle_data: got %h want 8000", data); else n_pass++;
        n_checks++; if (level !== 5'd5) $display("FAIL idle_level: got %0d want 5", level); else n_pass++;
        n_checks++; if (tick_cnt !== t0) $display("FAIL idle_no_tick: got %0d ticks want 0", tick_cnt - t0); else n_pass++;
    endtask

    task automatic test_playback();
        int t0, t, prev;
        do_reset();
        push_seq(16'h0001, 8);
        n_checks++; if (level !== 5'd8) $display("FAIL play_prefill_level: got %0d want 8", level); else n_pass++;
        period = 8'd4;
        enable = 1'b1;
        t0 = cyc;
        prev = t0;
        for (int k = 1; k <= 8; k++) begin
            wait_tick("play_tick", t);
            if (k == 1) begin
                n_checks++; if (t - t0 !== 4) $display("FAIL play_first_latency: got %0d want 4", t - t0); else n_pass++;
            end else begin
                n_checks++; if (t - prev !== 4) $display("FAIL play_spacing k=%0d: got %0d want 4", k, t - prev); else n_pass++;
            end
            n_checks++; if (data !== sample_t'(k)) $display("FAIL play_data k=%0d: got %h want %h", k, data, sample_t'(k)); else n_pass++;
            prev = t;
        end
        n_checks++; if (level !== 5'd0) $display("FAIL play_drained_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL play_underrun: got %b want 0", underrun); else n_pass++;
        enable = 1'b0;
        step();
        n_checks++; if (data !== 16'h8000) $display("FAIL play_disable_data: got %h want 8000", data); else n_pass++;
    endtask

    task automatic test_full();
        int t;
        sample_t exp;
        do_reset();
        src_if.in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                n_checks++; if (src_if.in_ready !== 1'b1) $display("FAIL full_ready_at15: got %b want 1", src_if.in_ready); else n_pass++;
            end
            src_if.in_data = 16'h0101 + sample_t'(i);
            step();
        end
        n_checks++; if (src_if.in_ready !== 1'b0) $display("FAIL full_ready_at16: got %b want 0", src_if.in_ready); else n_pass++;
        n_checks++; if (level !== 5'd16) $display("FAIL full_level: got %0d want 16", level); else n_pass++;
        src_if.in_data = 16'h0117;
        step();
        step();
        step();
        n_checks++; if (level !== 5'd16) $display("FAIL full_stall_level: got %0d want 16", level); else n_pass++;
        period = 8'd4;
        enable = 1'b1;
        step();
        step();
        step();
        n_checks++; if (data !== 16'h0101) $display("FAIL full_first_pop: got %h want 0101", data); else n_pass++;
        n_checks++; if (level !== 5'd15) $display("FAIL full_after_pop_level: got %0d want 15", level); else n_pass++;
        n_checks++; if (src_if.in_ready !== 1'b1) $display("FAIL full_after_pop_ready: got %b want 1", src_if.in_ready); else n_pass++;
        step();
        src_if.in_valid = 1'b0;
        n_checks++; if (level !== 5'd16) $display("FAIL full_17th_level: got %0d want 16", level); else n_pass++;
        period = 8'd2;
        for (int k = 2; k <= 17; k++) begin
            exp = (k <= 16) ? 16'h0100 + sample_t'(k) : 16'h0117;
            wait_tick("full_tick", t);
            n_checks++; if (data !== exp) $display("FAIL full_order k=%0d: got %h want %h", k, data, exp); else n_pass++;
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_underrun();
        int t, prev;
        do_reset();
        push_seq(16'h0A01, 8);
        period = 8'd3;
        enable = 1'b1;
        for (int k = 1; k <= 8; k++) wait_tick("ur_tick", prev);
        n_checks++; if (data !== 16'h0A08) $display("FAIL ur_last_data: got %h want 0A08", data); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL ur_before: got %b want 0", underrun); else n_pass++;
        wait_tick("ur_tick9", t);
        n_checks++; if (underrun !== 1'b1) $display("FAIL ur_set: got %b want 1", underrun); else n_pass++;
        n_checks++; if (data !== 16'h0A08) $display("FAIL ur_data_hold: got %h want 0A08", data); else n_pass++;
        n_checks++; if (t - prev !== 3) $display("FAIL ur_spacing9: got %0d want 3", t - prev); else n_pass++;
        prev = t;
        // Push lands in the same cycle as the next (empty) pop attempt.
        step();
        src_if.in_valid = 1'b1;
        src_if.in_data  = 16'h0BBB;
        step();
        src_if.in_valid = 1'b0;
        n_checks++; if (level !== 5'd1) $display("FAIL ur_nobypass_level: got %0d want 1", level); else n_pass++;
        wait_tick("ur_tick10", t);
        n_checks++; if (t - prev !== 3) $display("FAIL ur_spacing10: got %0d want 3", t - prev); else n_pass++;
        n_checks++; if (data !== 16'h0A08) $display("FAIL ur_nobypass_data: got %h want 0A08", data); else n_pass++;
        wait_tick("ur_tick11", t);
        n_checks++; if (data !== 16'h0BBB) $display("FAIL ur_stored_word: got %h want 0BBB", data); else n_pass++;
        enable = 1'b0;
        step();
        n_checks++; if (underrun !== 1'b1) $display("FAIL ur_sticky_idle: got %b want 1", underrun); else n_pass++;
        enable = 1'b1;
        step();
        n_checks++; if (underrun !== 1'b0) $display("FAIL ur_clear_prime: got %b want 0", underrun); else n_pass++;
        enable = 1'b0;
        step();
    endtask

    task automatic test_period();
        int a, b, d, e;
        do_reset();
        push_seq(16'h0C01, 8);
        period = 8'd0;
        enable = 1'b1;
        wait_tick("per_t1", a);
        wait_tick("per_t2", b);
        n_checks++; if (b - a !== 2) $display("FAIL per0_spacing_a: got %0d want 2", b - a); else n_pass++;
        wait_tick("per_t3", a);
        n_checks++; if (a - b !== 2) $display("FAIL per0_spacing_b: got %0d want 2", a - b); else n_pass++;
        period = 8'd1;
        wait_tick("per_t4", b);
        n_checks++; if (b - a !== 2) $display("FAIL per1_spacing_a: got %0d want 2", b - a); else n_pass++;
        wait_tick("per_t5", a);
        n_checks++; if (a - b !== 2) $display("FAIL per1_spacing_b: got %0d want 2", a - b); else n_pass++;
        // This cycle is a reload cycle, so the next interval is 10.
        period = 8'd10;
        wait_tick("per_t6", a);
        wait_tick("per_t7", b);
        n_checks++; if (b - a !== 10) $display("FAIL per10_spacing: got %0d want 10", b - a); else n_pass++;
        step();
        step();
        step();
        period = 8'd5;
        wait_tick("per_t8", d);
        n_checks++; if (d - b !== 10) $display("FAIL per_change_no_truncate: got %0d want 10", d - b); else n_pass++;
        wait_tick("per_t9", e);
        n_checks++; if (e - d !== 5) $display("FAIL per_change_next: got %0d want 5", e - d); else n_pass++;
        enable = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_run();
        int t, snap;
        do_reset();
        push_seq(16'h0D01, 8);
        period = 8'd4;
        enable = 1'b1;
        wait_tick("rmr_t1", t);
        wait_tick("rmr_t2", t);
        n_checks++; if (level !== 5'd6) $display("FAIL rmr_level_before: got %0d want 6", level); else n_pass++;
        step();
        step();
        // This cycle carries a pop attempt; reset must discard it.
        rst    = 1'b1;
        enable = 1'b0;
        snap   = tick_cnt;
        step();
        n_checks++; if (level !== 5'd0) $display("FAIL rmr_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (data !== 16'h8000) $display("FAIL rmr_data: got %h want 8000", data); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL rmr_underrun: got %b want 0", underrun); else n_pass++;
        n_checks++; if (dut.state !== ST_IDLE) $display("FAIL rmr_state: got %0d want %0d", dut.state, ST_IDLE); else n_pass++;
        rst = 1'b0;
        step();
        step();
        step();
        n_checks++; if (tick_cnt !== snap) $display("FAIL rmr_pending_tick: got %0d ticks want 0", tick_cnt - snap); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle_push();
        test_playback();
        test_full();
        test_underrun();
        test_period();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dac_sample_feeder.md
DAC_SAMPLE_FEEDER -- requirements
Module: dac_sample_feeder

Interface
REQ-001 Parameter DEPTH, default 16, sample FIFO depth in words (power of two, 4..64).
REQ-002 Parameter PRIME_LVL, default 8, FIFO level required before playback starts (1..DEPTH).
REQ-003 Parameter DIV_W, default 8, width of the sample-period input.
REQ-004 Parameter MIDSCALE, default 16'h8000, output code while not playing.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 enable  input  1  playback enable; low forces IDLE.
REQ-008 period  input  DIV_W  clocks per output sample; values below 2 are treated as 2.
REQ-009 in_data  input  16  unsigned sample from the producer.
REQ-010 in_valid  input  1  in_data is valid.
REQ-011 in_ready  output  1  FIFO can accept a word; equals not-full.
REQ-012 data  output  16  unsigned sample to the DAC serial driver, held stable between ticks.
REQ-013 sample_tick  output  1  one-cycle pulse in the cycle after data changes on a pop.
REQ-014 underrun  output  1  sticky flag, set on a pop attempt with the FIFO empty.
REQ-015 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 A push occurs in any cycle with in_valid and in_ready high, in every state; words are stored in arrival order.
REQ-017 FSM states: IDLE, PRIME, RUN.
REQ-018 IDLE: data = MIDSCALE; period counter held at 0; enable high -> PRIME next cycle.
REQ-019 PRIME: data holds; when level >= PRIME_LVL (after this cycle's push) -> RUN with counter loaded to 0, so the first pop occurs in the first RUN cycle.
REQ-020 RUN: counter decrements each cycle; at 0 a pop attempt occurs and the counter reloads to max(period,2)-1, sampled in that cycle.
REQ-021 Pop with level > 0: data <= FIFO head in the next cycle, level decrements, sample_tick pulses one cycle later than the data change.
REQ-022 Pop with level = 0: data holds its last value, underrun sets, sample_tick still pulses, FSM stays in RUN.
REQ-023 No bypass: a push and a pop attempt on an empty FIFO in the same cycle counts as underrun; the pushed word is stored.
REQ-024 A push and a pop in the same cycle with 0 < level < DEPTH leave level unchanged.
REQ-025 When full, in_ready is low and the producer stalls; no word is overwritten or dropped.
REQ-026 enable low in any state -> IDLE next cycle; FIFO contents are kept and data returns to MIDSCALE.
REQ-027 underrun clears only on rst or on the IDLE->PRIME transition.
REQ-028 A period change takes effect at the next reload and never truncates the current interval.
REQ-029 Pointers wrap modulo DEPTH; level never exceeds DEPTH.

Reset
REQ-030 Outputs after rst: data = MIDSCALE, sample_tick = 0, underrun = 0, level = 0, in_ready = 1.
REQ-031 Internal state after rst: FSM = IDLE, pointers = 0, counter = 0.
REQ-032 rst mid-RUN flushes the FIFO and discards any pending pop in the same cycle.

Structure
REQ-033 Shared package dac_pkg holds the FSM state typedef, MIDSCALE, and sample width 16, for reuse by the DAC serial driver.
REQ-034 The FIFO is sub-module sample_fifo (sync, registered read, level output); the FSM and period divider stay in the top level.

Verification
REQ-035 Reset, then enable = 0 with 5 pushes -> data = 16'h8000, level = 5, no sample_tick.
REQ-036 Push 8 words 0x0001..0x0008, period = 4, enable = 1 -> RUN; data steps 1..8 every 4 clocks; tick spacing is exactly 4.
REQ-037 Hold in_valid high with enable low -> in_ready drops at level 16; the 17th word is accepted only after a pop.
REQ-038 PRIME_LVL words, period = 3, no further pushes -> after the 8th sample, underrun = 1, data stays at the last value, ticks continue.
REQ-039 period = 0 or 1 -> ticks every 2 clocks; period changed from 10 to 5 mid-interval -> the current interval completes at 10, the next is 5.
REQ-040 rst asserted mid-RUN with level = 6 -> next cycle level = 0, data = 16'h8000, underrun = 0, FSM = IDLE.
